// File: rtl/ita_weight_write_streamer.sv
// Transmit side of the ITA weight write port: streams weight chunks onto a one-hot
// write bus into the weight buffer and hands each completed tile over with a commit handshake.
module ita_weight_write_streamer #(
    parameter int N          = 16,
    parameter int M          = 64,
    parameter int WI         = 8,
    parameter int N_WRITE_EN = 8,
    localparam int CW        = N * M * WI / N_WRITE_EN
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [31:0]                n_tiles_i,
    input  logic                       chunk_valid_i,
    output logic                       chunk_ready_o,
    input  logic [CW-1:0]              chunk_data_i,
    output logic [N_WRITE_EN-1:0]      write_select_o,
    output logic [N_WRITE_EN*CW-1:0]   write_data_o,
    output logic                       weight_valid_o,
    input  logic                       weight_ready_i,
    output logic                       busy_o,
    output logic                       done_o
);

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IW = idx_width(N_WRITE_EN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             n_tiles_q, n_tiles_d;
    logic [31:0]             tile_cnt_q, tile_cnt_d;
    logic [IW-1:0]           chunk_idx_q, chunk_idx_d;
    logic                    done_q, done_d;
    logic [N_WRITE_EN-1:0]   write_select_q, write_select_d;
    logic [N_WRITE_EN*CW-1:0] write_data_q, write_data_d;
    logic                    xfer;

    always_comb begin
        state_d        = state_q;
        n_tiles_d      = n_tiles_q;
        tile_cnt_d     = tile_cnt_q;
        chunk_idx_d    = chunk_idx_q;
        done_d         = 1'b0;
        chunk_ready_o  = 1'b0;
        weight_valid_o = 1'b0;
        xfer           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_tiles_d   = n_tiles_i;
                    chunk_idx_d = '0;
                    tile_cnt_d  = '0;
                    if (n_tiles_i == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                chunk_ready_o = 1'b1;
                xfer          = chunk_valid_i;
                if (xfer) begin
                    if (chunk_idx_q == IW'(N_WRITE_EN - 1)) begin
                        chunk_idx_d = '0;
                        state_d     = S_COMMIT;
                    end else begin
                        chunk_idx_d = chunk_idx_q + IW'(1);
                    end
                end
            end
            S_COMMIT: begin
                weight_valid_o = 1'b1;
                if (weight_ready_i) begin
                    tile_cnt_d = tile_cnt_q + 32'd1;
                    // The tile just committed is the last one when the incremented count reaches the job size.
                    if (tile_cnt_q + 32'd1 == n_tiles_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Write port: one registered cycle after each transfer, only the addressed slice carries data.
    always_comb begin
        write_select_d = xfer ? (N_WRITE_EN'(1) << chunk_idx_q) : '0;
        write_data_d   = '0;
        for (int i = 0; i < N_WRITE_EN; i++) begin
            write_data_d[i*CW +: CW] = write_select_d[i] ? chunk_data_i : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            n_tiles_q      <= '0;
            tile_cnt_q     <= '0;
            chunk_idx_q    <= '0;
            done_q         <= 1'b0;
            write_select_q <= '0;
            write_data_q   <= '0;
        end else begin
            state_q        <= state_d;
            n_tiles_q      <= n_tiles_d;
            tile_cnt_q     <= tile_cnt_d;
            chunk_idx_q    <= chunk_idx_d;
            done_q         <= done_d;
            write_select_q <= write_select_d;
            write_data_q   <= write_data_d;
        end
    end

    assign write_select_o = write_select_q;
    assign write_data_o   = write_data_q;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = done_q;

endmodule
